// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array result path.
// relu_elem is only referenced when DRAIN_RELU_EN is defined.
package systolic_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;

    localparam int DEFAULT_ROWS     = 64;
    localparam int DEFAULT_COLS     = 64;
    localparam int DEFAULT_OP_WIDTH = 32;
    localparam int CYCLE_W          = 32;

    // Elements are widened to this width before clamping, so op_width must not exceed it.
    localparam int ELEM_MAX_W = 64;

    function automatic logic [ELEM_MAX_W-1:0] relu_elem(
        input logic [ELEM_MAX_W-1:0] elem,
        input logic [5:0]            sign_pos
    );
        return elem[sign_pos] ? '0 : elem;
    endfunction

endpackage

// File: rtl/systolic_result_drain.sv
// Captures a finished rows x cols accumulator matrix and streams it out one row per beat.
// Define DRAIN_RELU_EN to clamp negative elements to zero on the output path.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int rows     = DEFAULT_ROWS,
    parameter int cols     = DEFAULT_COLS,
    parameter int op_width = DEFAULT_OP_WIDTH,
    localparam int ROW_W   = (rows > 1) ? $clog2(rows) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            compute_done,
    input  logic [CYCLE_W-1:0]              cycles_count,
    input  logic [rows*cols*op_width-1:0]   output_matrix,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [cols*op_width-1:0]        out_data,
    output logic [ROW_W-1:0]                out_row,
    output logic                            out_last,
    output logic [CYCLE_W-1:0]              frame_cycles,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            drop_err
);

    localparam int ROW_BITS = cols * op_width;

    drain_state_t          state_q, state_d;
    logic                  done_q, done_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic                  last_q, last_d;
    logic [ROW_BITS-1:0]   data_q, data_d;
    logic                  frame_done_q, frame_done_d;
    logic                  drop_err_q, drop_err_d;
    logic [CYCLE_W-1:0]    frame_cycles_q, frame_cycles_d;

    logic [ROW_BITS-1:0]   frame_q [rows];

    logic                  start;
    logic                  beat;
    logic                  last_hs;
    logic                  capture;
    logic                  drop;
    logic [ROW_BITS-1:0]   row_sel;
    logic [ROW_BITS-1:0]   row_out;

    assign start   = compute_done & ~done_q;
    assign beat    = (state_q == STREAM) & out_ready;
    assign last_hs = beat & last_q;
    // A new frame is accepted when idle or exactly as the last beat leaves.
    assign capture = start & ((state_q == IDLE) | last_hs);
    assign drop    = start & (state_q == STREAM) & ~last_hs;

    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        done_d         = compute_done;
        frame_done_d   = last_hs;
        drop_err_d     = drop_err_q | drop;
        frame_cycles_d = capture ? cycles_count : frame_cycles_q;
        if (capture) begin
            state_d = STREAM;
            row_d   = '0;
        end else if (beat) begin
            if (last_q) begin
                state_d = IDLE;
                row_d   = '0;
            end else begin
                row_d = row_q + ROW_W'(1);
            end
        end
    end

    // Row 0 of a fresh capture comes straight from the input since the buffer updates on the same edge.
    assign row_sel = capture ? output_matrix[ROW_BITS-1:0] : frame_q[row_d];

`ifdef DRAIN_RELU_EN
    for (genvar gi = 0; gi < cols; gi++) begin : g_relu
        logic [ELEM_MAX_W-1:0] elem_full;
        assign elem_full = relu_elem(ELEM_MAX_W'(row_sel[gi*op_width +: op_width]), 6'(op_width - 1));
        assign row_out[gi*op_width +: op_width] = elem_full[op_width-1:0];
    end
`else
    assign row_out = row_sel;
`endif

    always_comb begin
        last_d = (state_d == STREAM) && (row_d == ROW_W'(rows - 1));
        data_d = (state_d == STREAM) ? row_out : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            done_q         <= 1'b0;
            row_q          <= '0;
            last_q         <= 1'b0;
            data_q         <= '0;
            frame_done_q   <= 1'b0;
            drop_err_q     <= 1'b0;
            frame_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            done_q         <= done_d;
            row_q          <= row_d;
            last_q         <= last_d;
            data_q         <= data_d;
            frame_done_q   <= frame_done_d;
            drop_err_q     <= drop_err_d;
            frame_cycles_q <= frame_cycles_d;
        end
    end

    // Frame buffer carries no reset; its contents only matter after a capture.
    always_ff @(posedge clk) begin
        if (capture && !rst) begin
            for (int r = 0; r < rows; r++) begin
                frame_q[r] <= output_matrix[r*ROW_BITS +: ROW_BITS];
            end
        end
    end

    assign out_valid    = (state_q == STREAM);
    assign busy         = (state_q == STREAM);
    assign out_row      = row_q;
    assign out_last     = last_q;
    assign out_data     = data_q;
    assign frame_done   = frame_done_q;
    assign drop_err     = drop_err_q;
    assign frame_cycles = frame_cycles_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed, table-driven bench for systolic_result_drain with a 4x4 array of 32-bit elements.
// Expectations for the negative element follow DRAIN_RELU_EN when it is defined for the build.
module tb_systolic_result_drain;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int OPW  = 32;
    localparam int FA   = 0;
    localparam int FB   = 1;
    localparam int FN   = 2;

    logic                       clk;
    logic                       rst;
    logic                       compute_done;
    logic [31:0]                cycles_count;
    logic [ROWS*COLS*OPW-1:0]   output_matrix;
    logic                       out_valid;
    logic                       out_ready;
    logic [COLS*OPW-1:0]        out_data;
    logic [1:0]                 out_row;
    logic                       out_last;
    logic [31:0]                frame_cycles;
    logic                       busy;
    logic                       frame_done;
    logic                       drop_err;

    systolic_result_drain #(.rows(ROWS), .cols(COLS), .op_width(OPW)) dut (
        .clk(clk), .rst(rst), .compute_done(compute_done), .cycles_count(cycles_count),
        .output_matrix(output_matrix), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_last(out_last),
        .frame_cycles(frame_cycles), .busy(busy), .frame_done(frame_done), .drop_err(drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mon_beats = 0;
    int mon_row = 0;

    typedef struct {
        bit          rst;
        bit          cd;
        bit          rdy;
        int          fsel;
        int unsigned cyc;
        bit          ev;
        int          erow;
        bit          elast;
        bit          efd;
        bit          ederr;
        int          efr;
        int unsigned efc;
        int          ebeats;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] elem(input int fs, input int r, input int c);
        if (fs == FN && r == 0 && c == 0) return 32'hFFFF_FFF6;
        return 32'((fs == FB ? 100 : 0) + r * 4 + c);
    endfunction

    function automatic logic [127:0] exp_row(input int fs, input int r, input bit v);
        logic [127:0] res;
        logic [31:0]  e;
        res = '0;
        if (v) begin
            for (int c = 0; c < COLS; c++) begin
                e = elem(fs, r, c);
`ifdef DRAIN_RELU_EN
                if (e[31]) e = '0;
`endif
                res[c*32 +: 32] = e;
            end
        end
        return res;
    endfunction

    task automatic set_matrix(input int fs);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                output_matrix[(r*COLS+c)*OPW +: OPW] = elem(fs, r, c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit r, input bit cd, input bit rdy, input int fs, input int unsigned cy,
                       input bit ev, input int er, input bit el, input bit fd, input bit de,
                       input int ef, input int unsigned fc, input int eb);
        vec_t v;
        v.rst = r; v.cd = cd; v.rdy = rdy; v.fsel = fs; v.cyc = cy;
        v.ev = ev; v.erow = er; v.elast = el; v.efd = fd; v.ederr = de;
        v.efr = ef; v.efc = fc; v.ebeats = eb;
        vecs.push_back(v);
    endtask

    // Beat monitor: a beat transfers on the edge following a negedge that sees valid & ready.
    always @(negedge clk) begin
        if (rst) begin
            mon_beats = 0;
            mon_row   = 0;
        end else if (out_valid && out_ready) begin
            check("beat_row_order", 128'(out_row), 128'(mon_row));
            $display("beat row=%0d last=%0b data=%h", out_row, out_last, out_data);
            mon_beats++;
            mon_row = (mon_row == ROWS - 1) ? 0 : mon_row + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit got;
        vec_t v;

        rst = 1'b1; compute_done = 1'b0; out_ready = 1'b0; cycles_count = '0;
        set_matrix(FA);

        // reset state
        add(1,0,0,FA,0,  0,0,0,0,0,FA,0,-1);
        add(1,0,0,FA,0,  0,0,0,0,0,FA,0,0);
        // nominal stream
        add(0,1,1,FA,37, 1,0,0,0,0,FA,37,-1);
        add(0,0,1,FA,37, 1,1,0,0,0,FA,37,-1);
        add(0,0,1,FA,37, 1,2,0,0,0,FA,37,-1);
        add(0,0,1,FA,37, 1,3,1,0,0,FA,37,-1);
        add(0,0,1,FA,37, 0,0,0,1,0,FA,37,-1);
        add(0,0,1,FA,37, 0,0,0,0,0,FA,37,4);
        add(1,0,0,FA,0,  0,0,0,0,0,FA,0,0);
        // backpressure on row 2
        add(0,1,1,FA,5,  1,0,0,0,0,FA,5,-1);
        add(0,0,1,FA,5,  1,1,0,0,0,FA,5,-1);
        add(0,0,1,FA,5,  1,2,0,0,0,FA,5,-1);
        add(0,0,0,FA,5,  1,2,0,0,0,FA,5,-1);
        add(0,0,0,FA,5,  1,2,0,0,0,FA,5,-1);
        add(0,0,0,FA,5,  1,2,0,0,0,FA,5,-1);
        add(0,0,1,FA,5,  1,3,1,0,0,FA,5,-1);
        add(0,0,1,FA,5,  0,0,0,1,0,FA,5,-1);
        add(0,0,1,FA,5,  0,0,0,0,0,FA,5,4);
        add(1,0,0,FA,0,  0,0,0,0,0,FA,0,0);
        // second rise on row 1 is dropped
        add(0,1,1,FA,7,  1,0,0,0,0,FA,7,-1);
        add(0,0,1,FA,7,  1,1,0,0,0,FA,7,-1);
        add(0,1,1,FB,8,  1,2,0,0,1,FA,7,-1);
        add(0,0,1,FB,8,  1,3,1,0,1,FA,7,-1);
        add(0,0,1,FB,8,  0,0,0,1,1,FA,7,-1);
        add(0,0,1,FB,8,  0,0,0,0,1,FA,7,4);
        add(1,0,0,FA,0,  0,0,0,0,0,FA,0,0);
        // back-to-back frames
        add(0,1,1,FA,11, 1,0,0,0,0,FA,11,-1);
        add(0,0,1,FA,11, 1,1,0,0,0,FA,11,-1);
        add(0,0,1,FA,11, 1,2,0,0,0,FA,11,-1);
        add(0,0,1,FA,11, 1,3,1,0,0,FA,11,-1);
        add(0,1,1,FB,12, 1,0,0,1,0,FB,12,-1);
        add(0,0,1,FB,12, 1,1,0,0,0,FB,12,-1);
        add(0,0,1,FB,12, 1,2,0,0,0,FB,12,-1);
        add(0,0,1,FB,12, 1,3,1,0,0,FB,12,-1);
        add(0,0,1,FB,12, 0,0,0,1,0,FB,12,-1);
        add(0,0,1,FB,12, 0,0,0,0,0,FB,12,8);
        add(1,0,0,FA,0,  0,0,0,0,0,FA,0,0);
        // compute_done held high gives only one frame
        add(0,1,1,FA,20, 1,0,0,0,0,FA,20,-1);
        add(0,1,1,FA,20, 1,1,0,0,0,FA,20,-1);
        add(0,1,1,FA,20, 1,2,0,0,0,FA,20,-1);
        add(0,1,1,FA,20, 1,3,1,0,0,FA,20,-1);
        add(0,1,1,FA,20, 0,0,0,1,0,FA,20,-1);
        add(0,1,1,FA,20, 0,0,0,0,0,FA,20,-1);
        add(0,1,1,FA,20, 0,0,0,0,0,FA,20,4);
        add(1,0,0,FA,0,  0,0,0,0,0,FA,0,0);
        // reset while row 1 is on the bus
        add(0,1,1,FA,30, 1,0,0,0,0,FA,30,-1);
        add(0,0,1,FA,30, 1,1,0,0,0,FA,30,-1);
        add(1,0,1,FA,30, 0,0,0,0,0,FA,0,0);
        add(0,0,1,FA,30, 0,0,0,0,0,FA,0,-1);
        add(0,0,1,FA,30, 0,0,0,0,0,FA,0,0);
        // negative element in (0,0)
        add(0,1,1,FN,40, 1,0,0,0,0,FN,40,-1);
        add(0,0,1,FN,40, 1,1,0,0,0,FN,40,-1);
        add(0,0,1,FN,40, 1,2,0,0,0,FN,40,-1);
        add(0,0,1,FN,40, 1,3,1,0,0,FN,40,-1);
        add(0,0,1,FN,40, 0,0,0,1,0,FN,40,-1);
        add(0,0,1,FN,40, 0,0,0,0,0,FN,40,4);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            rst = v.rst; compute_done = v.cd; out_ready = v.rdy; cycles_count = v.cyc;
            set_matrix(v.fsel);
            tick();
            check($sformatf("v%0d_valid", i), 128'(out_valid), 128'(v.ev));
            check($sformatf("v%0d_busy", i), 128'(busy), 128'(v.ev));
            check($sformatf("v%0d_row", i), 128'(out_row), 128'(v.erow));
            check($sformatf("v%0d_last", i), 128'(out_last), 128'(v.elast));
            check($sformatf("v%0d_frame_done", i), 128'(frame_done), 128'(v.efd));
            check($sformatf("v%0d_drop_err", i), 128'(drop_err), 128'(v.ederr));
            check($sformatf("v%0d_frame_cycles", i), 128'(frame_cycles), 128'(v.efc));
            check($sformatf("v%0d_data", i), out_data, exp_row(v.efr, v.erow, v.ev));
            if (v.ebeats >= 0)
                check($sformatf("v%0d_beats", i), 128'(mon_beats), 128'(v.ebeats));
        end

        // frame_done latency with a bounded wait
        set_matrix(FA); cycles_count = 55; compute_done = 1'b1; out_ready = 1'b1;
        tick();
        check("seq_first_valid", 128'(out_valid), 128'(1));
        compute_done = 1'b0;
        n = 0;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            n++;
            if (frame_done) begin
                got = 1'b1;
                break;
            end
        end
        if (got) check("seq_fd_latency", 128'(n), 128'(ROWS));
        else     check("seq_fd_timeout", 128'(got), 128'(1));
        check("seq_frame_cycles", 128'(frame_cycles), 128'(55));

        // negative element on the first beat
        tick();
        set_matrix(FN); cycles_count = 41; compute_done = 1'b1;
        tick();
`ifdef DRAIN_RELU_EN
        check("seq_relu_elem00", 128'(out_data[31:0]), 128'(32'h0000_0000));
`else
        check("seq_relu_elem00", 128'(out_data[31:0]), 128'(32'hFFFF_FFF6));
`endif
        compute_done = 1'b0;
        repeat (6) tick();
        check("seq_idle_after_drain", 128'(out_valid), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
